// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit with a 32-cycle shift-add or restoring-division core.
// Operands are converted to magnitudes at launch, and the stored sign is applied to the result on completion.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_op;
   logic        r_neg;
   logic [4:0]  r_count;
   logic [63:0] r_acc;
   logic [31:0] r_div;
   logic [31:0] r_result;

   logic        w_accept;
   logic        w_div_zero;
   logic        w_last;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_neg_start;
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_diff;
   logic [63:0] w_acc_next;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_final;

   assign w_accept    = start && (r_state != CALC);
   assign w_div_zero  = op[1] && (op_b == 32'd0);
   assign w_last      = (r_count == 5'd31);
   // 0x80000000 negates to itself, which reads correctly as the unsigned magnitude 2^31.
   assign w_a_mag     = op_a[31] ? (32'd0 - op_a) : op_a;
   assign w_b_mag     = op_b[31] ? (32'd0 - op_b) : op_b;
   assign w_neg_start = (op == 2'b11) ? op_a[31] : (op_a[31] ^ op_b[31]);

   // Multiply shifts the multiplier out of the low half while the product grows in the high half.
   // Divide shifts the dividend out of the low half, the remainder builds up in the high half,
   // and quotient bits enter at the bottom.
   always_comb begin
      w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_div} : 33'd0);
      w_div_diff = {1'b0, r_acc[62:31]} - {1'b0, r_div};
      if (!r_op[1]) begin
         w_acc_next = {w_mul_sum, r_acc[31:1]};
      end else if (!w_div_diff[32]) begin
         w_acc_next = {w_div_diff[31:0], r_acc[30:0], 1'b1};
      end else begin
         w_acc_next = {r_acc[62:0], 1'b0};
      end
   end

   always_comb begin
      w_prod_fix = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
      w_quo_fix  = r_neg ? (32'd0 - w_acc_next[31:0]) : w_acc_next[31:0];
      w_rem_fix  = r_neg ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];
      case (r_op)
         OP_MUL:  w_final = w_prod_fix[31:0];
         OP_MULH: w_final = w_prod_fix[63:32];
         OP_DIV:  w_final = w_quo_fix;
         default: w_final = w_rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = w_div_zero ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               w_next = w_div_zero ? DONE : CALC;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // A division by zero resolves in the accept cycle; all other results land on the final CALC edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= 2'b00;
         r_neg    <= 1'b0;
         r_count  <= 5'd0;
         r_acc    <= 64'd0;
         r_div    <= 32'd0;
         r_result <= 32'd0;
      end else if (w_accept) begin
         r_op    <= op;
         r_neg   <= w_neg_start;
         r_count <= 5'd0;
         r_acc   <= {32'd0, w_a_mag};
         r_div   <= w_b_mag;
         if (w_div_zero) begin
            r_result <= op[0] ? op_a : 32'hFFFF_FFFF;
         end
      end else if (r_state == CALC) begin
         r_acc   <= w_acc_next;
         r_count <= r_count + 5'd1;
         if (w_last) begin
            r_result <= w_final;
         end
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences and random ops
// compared against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] opA = 32'd0;
   logic [31:0] opB = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expResult;
      int          expLat;
   } vec_t;

   vec_t vecs[12];

   mul_div_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .op_a   (opA),
      .op_b   (opB),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before test completion");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: plain signed 64-bit arithmetic, with the division-by-zero rules applied.
   function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin r = sa * sb; return r[31:0]; end
         2'b01: begin r = sa * sb; return r[63:32]; end
         2'b10: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            r = sa / sb;
            return r[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            r = sa % sb;
            return r[31:0];
         end
      endcase
   endfunction

   function automatic int refLatency(input logic [1:0] o, input logic [31:0] b);
      return (o[1] && b == 32'd0) ? 1 : 33;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Latency counts edges from the accepting edge k: a sample taken after edge k+j is reported as k+j+1.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int busyCnt, output logic [31:0] res);
      @(negedge clk);
      op = o;
      opA = a;
      opB = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom_range(0, 3));
      opA = $urandom;
      opB = $urandom;
      lat = 0;
      busyCnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (busy) busyCnt++;
         if (done) begin
            lat = j + 1;
            break;
         end
         @(negedge clk);
      end
      res = result;
   endtask

   initial begin
      int lat;
      int busyCnt;
      int firstT;
      int secondT;
      int doneSeen;
      logic [31:0] res;
      logic [1:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;

      vecs[0]  = '{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{2'b01, 32'h4000_0000, 32'd4,         32'h0000_0001, 33};
      vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vecs[3]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[4]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 1};
      vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[8]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33};
      vecs[10] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[11] = '{2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 33};

      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", result, 32'd0);

      // First start lands on the very first edge after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      op = 2'b00;
      opA = 32'd7;
      opB = 32'hFFFF_FFFD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busyCnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (busy) busyCnt++;
         if (done) begin
            lat = j + 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("first_start_latency", 32'(lat), 32'd33);
      checkOutput("first_start_busy_cycles", 32'(busyCnt), 32'd32);
      checkOutput("first_start_result", result, 32'hFFFF_FFEB);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCnt, res);
         checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expResult);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(busyCnt), (vecs[i].expLat == 1) ? 32'd0 : 32'd32);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse_ends", i), 32'(done), 32'd0);
         checkOutput($sformatf("vec%0d_result_held", i), result, vecs[i].expResult);
      end

      // A start pulse mid-operation (a division by zero that would finish at once) must be ignored.
      @(negedge clk);
      op = 2'b00;
      opA = 32'd3;
      opB = 32'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int j = 0; j < 40; j++) begin
         if (done) begin
            lat = j + 1;
            break;
         end
         if (j == 9) begin
            start = 1'b1;
            op = 2'b10;
            opA = 32'd100;
            opB = 32'd0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("ignore_start_latency", 32'(lat), 32'd33);
      checkOutput("ignore_start_result", result, 32'h0000_000C);

      // Back-to-back: the second op is launched from DONE while the first op's done pulse is visible.
      @(negedge clk);
      op = 2'b00;
      opA = 32'd3;
      opB = 32'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      firstT = 0;
      secondT = 0;
      for (int j = 0; j < 80; j++) begin
         if (done && firstT == 0) begin
            firstT = j + 1;
            checkOutput("b2b_first_result", result, 32'h0000_000C);
            start = 1'b1;
            op = 2'b10;
            opA = 32'hFFFF_FFEC;
            opB = 32'd3;
         end else begin
            start = 1'b0;
            if (done && firstT != 0) begin
               secondT = j + 1;
               break;
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("b2b_first_latency", 32'(firstT), 32'd33);
      checkOutput("b2b_second_latency", 32'(secondT), 32'd66);
      checkOutput("b2b_second_result", result, 32'hFFFF_FFFA);

      // Reset in the middle of a division aborts it with no trailing done pulse.
      @(negedge clk);
      op = 2'b10;
      opA = 32'd1000;
      opB = 32'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midop_reset_busy", 32'(busy), 32'd0);
      checkOutput("midop_reset_done", 32'(done), 32'd0);
      checkOutput("midop_reset_result", result, 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      for (int j = 0; j < 41; j++) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("post_reset_no_done", 32'(doneSeen), 32'd0);

      // Random operations compared against the reference model.
      for (int i = 0; i < 30; i++) begin
         rOp = 2'($urandom_range(0, 3));
         rA = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: rB = 32'd0;
            1: rB = 32'($urandom_range(1, 15));
            2: rB = 32'hFFFF_FFFF;
            default: rB = $urandom;
         endcase
         applyStimulus(rOp, rA, rB, lat, busyCnt, res);
         checkOutput($sformatf("rand%0d_op%0d_result", i, rOp), res, refResult(rOp, rA, rB));
         checkOutput($sformatf("rand%0d_op%0d_latency", i, rOp), 32'(lat), 32'(refLatency(rOp, rB)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request; accepted only when busy=0.
REQ-004 op  input  2  operation: 00 MUL, 01 MULH, 10 DIV, 11 REM.
REQ-005 op_a  input  32 signed  operand A / dividend, from operand-A select mux.
REQ-006 op_b  input  32 signed  operand B / divisor, from operand-B select mux.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse when result becomes valid.
REQ-009 result  output  32 signed  last completed result, held until the next completion.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-011 In IDLE or DONE with start=1, the unit SHALL latch op, op_a and op_b at that edge; later changes on these inputs SHALL NOT affect the operation.
REQ-012 start=1 while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-013 An accepted non-div-by-zero op SHALL enter CALC for exactly 32 cycles, then DONE for 1 cycle, then IDLE unless start=1 in DONE.
REQ-014 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-015 If start is sampled at edge k, done SHALL be high after edge k+33 (latency 33) for MUL/MULH/DIV/REM, and after edge k+1 for division by zero.
REQ-016 result SHALL update on the edge entering DONE and SHALL hold otherwise.
REQ-017 MUL: result SHALL be bits [31:0] of the signed 64-bit product op_a*op_b.
REQ-018 MULH: result SHALL be bits [63:32] of the signed 64-bit product.
REQ-019 Multiply SHALL be iterative shift-add, one partial-product bit per CALC cycle, on operand magnitudes with sign fixed at completion.
REQ-020 DIV/REM SHALL use iterative restoring division on magnitudes, one quotient bit per CALC cycle.
REQ-021 DIV quotient SHALL truncate toward zero; REM remainder SHALL take the dividend's sign.
REQ-022 Divisor 0: IDLE/DONE->DONE directly, skipping CALC; DIV result 0xFFFFFFFF, REM result = op_a.
REQ-023 Overflow op_a=0x80000000, op_b=0xFFFFFFFF: DIV result 0x80000000, REM result 0, at normal 33-cycle latency.
REQ-024 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31; negation SHALL wrap modulo 2^32.
REQ-025 start=1 in DONE SHALL launch the next op back-to-back; done pulse for the completed op SHALL still occur in that cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, clearing all iteration counters and internal registers, independent of clk.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse for it SHALL ever appear after reset release.
REQ-028 The first start SHALL be accepted at the first rising edge with rst_n=1.

Verification
REQ-029 MUL 7 * -3 (op=00), start at edge k -> busy high edges k+1..k+32, done at k+33, result 0xFFFFFFEB; MULH 0x40000000*4 -> result 0x00000001.
REQ-030 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 0x00000001.
REQ-031 DIV 5/0 -> done after edge k+1, busy never high, result 0xFFFFFFFF; REM 5/0 -> result 0x00000005.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at k+33; REM same operands -> 0x00000000.
REQ-033 Start MUL 3*4, pulse start with other operands at k+10 -> ignored, result 0x0000000C at k+33; start asserted in DONE -> second op done at k+66.
REQ-034 Assert rst_n=0 at k+15 of a DIV, release at k+20 -> busy=0, done=0, result=0 immediately; no done through k+60.
